ball_frame_sequencer: RTL and testbench

// - Per-frame sequencer for the ball datapath: on each frame strobe, drives the ball's request/ack handshake step by step.
// - Forwards each reported ball position to the shared collision checker.
// - Turns a checker hit into the one-cycle collision cue plus direction code the ball consumes.
// - Sits between the top-level frame timer, the ball, and the collision checker; reports frame completion and watchdog errors upward.

---
 rtl/ball_pkg.sv | 24 ++
 rtl/seq_watchdog.sv | 41 ++++
 rtl/ball_frame_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_ball_frame_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// Shared types and constants for the ball frame datapath.
// No logic; pure declarations.
// No handshakes live here; consumers own their own flow control.
package ball_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_CHECK    = 3'd2,
    S_WAIT_CHK = 3'd3,
    S_APPLY    = 3'd4,
    S_DONE     = 3'd5
  } seq_state_t;

  // Direction codes beyond the platform range (1..16).
  localparam int DIR_XFLIP = 18;
  localparam int DIR_YFLIP = 19;

  // Per-step speed codes.
  localparam logic [1:0] SPD_ZERO = 2'b00;
  localparam logic [1:0] SPD_POS  = 2'b01;
  localparam logic [1:0] SPD_NEG  = 2'b11;

endpackage

// File: rtl/seq_watchdog.sv
// Wait-state watchdog: counts cycles while enabled, flags expiry before the count reaches TIMEOUT.
// Latency: o_expire is combinational from the count register; fires in the TIMEOUT-th enabled cycle.
// No backpressure; i_clr has priority over counting.
module seq_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_BITS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;

  // Next count: clear on request, otherwise saturating increment while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != TO_BITS'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expire in the cycle whose increment would bring the count to TIMEOUT,
  // so a wait state lasts exactly TIMEOUT cycles before abort.
  assign o_expire = i_en && (cnt_q == TO_BITS'(TIMEOUT - 1));

endmodule

// File: rtl/ball_frame_sequencer.sv
// Per-frame ball sequencer: steps ball req/ack, forwards positions to the checker, turns hits into collision cues.
// Latency: ack -> o_chk_req 1 cycle; chk_done(hit) -> o_ball_collision 1 cycle; collision -> o_ball_req 1 cycle.
// Ball side is a held level request; checker side is pulse/done; a watchdog aborts any wait that stalls.
`ifndef PIXELX_BIT_CNT
`define PIXELX_BIT_CNT 10
`endif
`ifndef PIXELY_BIT_CNT
`define PIXELY_BIT_CNT 9
`endif
`ifndef BALL_SIZE_BIT_CNT
`define BALL_SIZE_BIT_CNT 4
`endif
`ifndef DIR_BIT_CNT
`define DIR_BIT_CNT 5
`endif

module ball_frame_sequencer
  import ball_pkg::*;
#(
  parameter int MAX_STEPS = 8,
  parameter int TIMEOUT   = 255,
  parameter int TO_BITS   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_cal_frame,
  input  logic                          i_game_start,
  output logic                          o_ball_req,
  input  logic                          i_ball_ack,
  input  logic                          i_ball_frame_term,
  input  logic [`PIXELX_BIT_CNT-1:0]    i_ballX,
  input  logic [`PIXELY_BIT_CNT-1:0]    i_ballY,
  input  logic [`BALL_SIZE_BIT_CNT-1:0] i_ball_size,
  input  logic [1:0]                    i_ball_speedX,
  input  logic [1:0]                    i_ball_speedY,
  output logic                          o_chk_req,
  output logic [`PIXELX_BIT_CNT-1:0]    o_chkX,
  output logic [`PIXELY_BIT_CNT-1:0]    o_chkY,
  output logic [`BALL_SIZE_BIT_CNT-1:0] o_chk_size,
  output logic [1:0]                    o_chk_speedX,
  output logic [1:0]                    o_chk_speedY,
  input  logic                          i_chk_done,
  input  logic                          i_chk_hit,
  input  logic [`DIR_BIT_CNT-1:0]       i_chk_dir,
  output logic                          o_ball_collision,
  output logic [`DIR_BIT_CNT-1:0]       o_direc_var,
  output logic                          o_frame_done,
  output logic                          o_busy,
  output logic                          o_err,
  output logic [2:0]                    o_state
);

  localparam int STEP_BITS = $clog2(MAX_STEPS + 1);
  localparam logic [STEP_BITS-1:0] STEP_MAX = STEP_BITS'(MAX_STEPS);

  seq_state_t state_q, state_d;
  logic [STEP_BITS-1:0]          step_cnt_q, step_cnt_d;
  logic                          err_q, err_d;
  logic [`DIR_BIT_CNT-1:0]       direc_q, direc_d;
  logic [`PIXELX_BIT_CNT-1:0]    chk_x_q, chk_x_d;
  logic [`PIXELY_BIT_CNT-1:0]    chk_y_q, chk_y_d;
  logic [`BALL_SIZE_BIT_CNT-1:0] chk_size_q, chk_size_d;
  logic [1:0]                    chk_spx_q, chk_spx_d;
  logic [1:0]                    chk_spy_q, chk_spy_d;
  logic                          ball_req_q, chk_req_q, coll_q, frame_done_q;
  logic                          wd_expire;

  // Watchdog restarts on every state change; only the two wait states count.
  seq_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_BITS (TO_BITS)
  ) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (state_d != state_q),
    .i_en     ((state_q == S_REQ) || (state_q == S_WAIT_CHK)),
    .o_expire (wd_expire)
  );

  // Next-state and datapath updates; game_start overrides everything.
  always_comb begin
    state_d    = state_q;
    step_cnt_d = step_cnt_q;
    err_d      = err_q;
    direc_d    = direc_q;
    chk_x_d    = chk_x_q;
    chk_y_d    = chk_y_q;
    chk_size_d = chk_size_q;
    chk_spx_d  = chk_spx_q;
    chk_spy_d  = chk_spy_q;
    if (i_game_start) begin
      state_d    = S_IDLE;
      step_cnt_d = '0;
      err_d      = 1'b0;
      direc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_cal_frame) begin
            state_d    = S_REQ;
            step_cnt_d = '0;
          end
        end
        S_REQ: begin
          // frame_term wins over a coincident ack.
          if (i_ball_frame_term) begin
            state_d = S_DONE;
          end else if (i_ball_ack) begin
            chk_x_d    = i_ballX;
            chk_y_d    = i_ballY;
            chk_size_d = i_ball_size;
            chk_spx_d  = i_ball_speedX;
            chk_spy_d  = i_ball_speedY;
            if (step_cnt_q != STEP_MAX) begin
              step_cnt_d = step_cnt_q + 1'b1;
            end
            state_d = S_CHECK;
          end else if (wd_expire) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        S_CHECK: begin
          state_d = S_WAIT_CHK;
        end
        S_WAIT_CHK: begin
          if (i_chk_done) begin
            if (i_chk_hit) begin
              direc_d = i_chk_dir;
              state_d = S_APPLY;
            end else if (step_cnt_q == STEP_MAX) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_REQ;
            end
          end else if (wd_expire) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
        S_APPLY: begin
          if (step_cnt_q == STEP_MAX) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_REQ;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered pulse outputs; pulses are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      step_cnt_q   <= '0;
      err_q        <= 1'b0;
      direc_q      <= '0;
      chk_x_q      <= '0;
      chk_y_q      <= '0;
      chk_size_q   <= '0;
      chk_spx_q    <= '0;
      chk_spy_q    <= '0;
      ball_req_q   <= 1'b0;
      chk_req_q    <= 1'b0;
      coll_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_cnt_q   <= step_cnt_d;
      err_q        <= err_d;
      direc_q      <= direc_d;
      chk_x_q      <= chk_x_d;
      chk_y_q      <= chk_y_d;
      chk_size_q   <= chk_size_d;
      chk_spx_q    <= chk_spx_d;
      chk_spy_q    <= chk_spy_d;
      ball_req_q   <= (state_d == S_REQ);
      chk_req_q    <= (state_d == S_CHECK);
      coll_q       <= (state_d == S_APPLY);
      frame_done_q <= (state_d == S_DONE);
    end
  end

  assign o_ball_req       = ball_req_q;
  assign o_chk_req        = chk_req_q;
  assign o_ball_collision = coll_q;
  assign o_frame_done     = frame_done_q;
  assign o_err            = err_q;
  assign o_direc_var      = direc_q;
  assign o_chkX           = chk_x_q;
  assign o_chkY           = chk_y_q;
  assign o_chk_size       = chk_size_q;
  assign o_chk_speedX     = chk_spx_q;
  assign o_chk_speedY     = chk_spy_q;
  assign o_busy           = (state_q != S_IDLE);
  assign o_state          = state_q;

endmodule

// File: tb/tb_ball_frame_sequencer.sv
// Directed bench for ball_frame_sequencer: reset, no-hit frame, hit frame, simultaneous term/ack,
// step overflow, watchdog abort, and game_start abort.
// Inputs change 1 time unit after each rising edge; outputs are read at that point.
`ifndef PIXELX_BIT_CNT
`define PIXELX_BIT_CNT 10
`endif
`ifndef PIXELY_BIT_CNT
`define PIXELY_BIT_CNT 9
`endif
`ifndef BALL_SIZE_BIT_CNT
`define BALL_SIZE_BIT_CNT 4
`endif
`ifndef DIR_BIT_CNT
`define DIR_BIT_CNT 5
`endif

module tb_ball_frame_sequencer;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          i_cal_frame, i_game_start;
  logic                          o_ball_req, i_ball_ack, i_ball_frame_term;
  logic [`PIXELX_BIT_CNT-1:0]    i_ballX;
  logic [`PIXELY_BIT_CNT-1:0]    i_ballY;
  logic [`BALL_SIZE_BIT_CNT-1:0] i_ball_size;
  logic [1:0]                    i_ball_speedX, i_ball_speedY;
  logic                          o_chk_req;
  logic [`PIXELX_BIT_CNT-1:0]    o_chkX;
  logic [`PIXELY_BIT_CNT-1:0]    o_chkY;
  logic [`BALL_SIZE_BIT_CNT-1:0] o_chk_size;
  logic [1:0]                    o_chk_speedX, o_chk_speedY;
  logic                          i_chk_done, i_chk_hit;
  logic [`DIR_BIT_CNT-1:0]       i_chk_dir;
  logic                          o_ball_collision;
  logic [`DIR_BIT_CNT-1:0]       o_direc_var;
  logic                          o_frame_done, o_busy, o_err;
  logic [2:0]                    o_state;

  int tests = 0;
  int fails = 0;
  int chk_pulses = 0;
  int coll_pulses = 0;
  int base_chk, base_coll;

  ball_frame_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_cal_frame       (i_cal_frame),
    .i_game_start      (i_game_start),
    .o_ball_req        (o_ball_req),
    .i_ball_ack        (i_ball_ack),
    .i_ball_frame_term (i_ball_frame_term),
    .i_ballX           (i_ballX),
    .i_ballY           (i_ballY),
    .i_ball_size       (i_ball_size),
    .i_ball_speedX     (i_ball_speedX),
    .i_ball_speedY     (i_ball_speedY),
    .o_chk_req         (o_chk_req),
    .o_chkX            (o_chkX),
    .o_chkY            (o_chkY),
    .o_chk_size        (o_chk_size),
    .o_chk_speedX      (o_chk_speedX),
    .o_chk_speedY      (o_chk_speedY),
    .i_chk_done        (i_chk_done),
    .i_chk_hit         (i_chk_hit),
    .i_chk_dir         (i_chk_dir),
    .o_ball_collision  (o_ball_collision),
    .o_direc_var       (o_direc_var),
    .o_frame_done      (o_frame_done),
    .o_busy            (o_busy),
    .o_err             (o_err),
    .o_state           (o_state)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (o_chk_req)        chk_pulses  <= chk_pulses + 1;
    if (o_ball_collision) coll_pulses <= coll_pulses + 1;
  end

  // Safety net in case the run stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_cal_frame = 0; i_game_start = 0; i_ball_ack = 0; i_ball_frame_term = 0;
    i_ballX = '0; i_ballY = '0; i_ball_size = '0; i_ball_speedX = '0; i_ball_speedY = '0;
    i_chk_done = 0; i_chk_hit = 0; i_chk_dir = '0;
    tick(); tick();

    // Reset state
    check("rst_state", o_state, 0);
    check("rst_ball_req", o_ball_req, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err, 0);
    check("rst_frame_done", o_frame_done, 0);
    check("rst_chkX", o_chkX, 0);
    check("rst_direc", o_direc_var, 0);
    rst_n = 1'b1;
    tick();

    // No-hit frame: three steps then frame_term
    base_chk = chk_pulses; base_coll = coll_pulses;
    i_cal_frame = 1; tick(); i_cal_frame = 0;
    check("nh_req", o_ball_req, 1);
    check("nh_state_req", o_state, 1);
    check("nh_busy", o_busy, 1);
    for (int s = 0; s < 3; s++) begin
      i_ball_ack = 1; i_ballX = 10'(100 + s); i_ballY = 9'(50 + s);
      tick(); i_ball_ack = 0;
      check("nh_chk_req", o_chk_req, 1);
      check("nh_req_low", o_ball_req, 0);
      check("nh_chkX", o_chkX, 100 + s);
      tick();
      check("nh_wait", o_state, 3);
      i_chk_done = 1; i_chk_hit = 0; tick(); i_chk_done = 0;
      check("nh_back_req", o_ball_req, 1);
    end
    i_ball_frame_term = 1; tick(); i_ball_frame_term = 0;
    check("nh_frame_done", o_frame_done, 1);
    tick();
    check("nh_frame_done_1cyc", o_frame_done, 0);
    check("nh_idle", o_state, 0);
    check("nh_err", o_err, 0);
    check("nh_chk_count", chk_pulses - base_chk, 3);
    check("nh_coll_count", coll_pulses - base_coll, 0);

    // Hit frame
    i_cal_frame = 1; tick(); i_cal_frame = 0;
    i_ball_ack = 1; i_ballX = 10'd320; i_ballY = 9'd100; i_ball_size = 4'd6;
    i_ball_speedX = 2'b01; i_ball_speedY = 2'b11;
    tick(); i_ball_ack = 0;
    check("hit_chkX", o_chkX, 320);
    check("hit_chkY", o_chkY, 100);
    check("hit_size", o_chk_size, 6);
    check("hit_spx", o_chk_speedX, 1);
    check("hit_spy", o_chk_speedY, 3);
    tick();
    i_chk_done = 1; i_chk_hit = 1; i_chk_dir = 5'd9; tick(); i_chk_done = 0; i_chk_hit = 0;
    check("hit_coll", o_ball_collision, 1);
    check("hit_dir", o_direc_var, 9);
    check("hit_req_low", o_ball_req, 0);
    tick();
    check("hit_coll_1cyc", o_ball_collision, 0);
    check("hit_next_req", o_ball_req, 1);
    check("hit_dir_held", o_direc_var, 9);
    i_ball_frame_term = 1; tick(); i_ball_frame_term = 0;
    tick();

    // Simultaneous ack and frame_term
    base_chk = chk_pulses;
    i_cal_frame = 1; tick(); i_cal_frame = 0;
    i_ball_ack = 1; i_ball_frame_term = 1; tick(); i_ball_ack = 0; i_ball_frame_term = 0;
    check("sim_chk_req", o_chk_req, 0);
    check("sim_state_done", o_state, 5);
    check("sim_frame_done", o_frame_done, 1);
    tick();
    check("sim_chk_count", chk_pulses - base_chk, 0);

    // Step overflow: ball never terminates
    base_chk = chk_pulses;
    i_cal_frame = 1; tick(); i_cal_frame = 0;
    for (int s = 0; s < 8; s++) begin
      i_ball_ack = 1; tick(); i_ball_ack = 0;
      tick();
      i_chk_done = 1; i_chk_hit = 0; tick(); i_chk_done = 0;
      if (s < 7) check("ovf_req", o_state, 1);
    end
    check("ovf_done", o_state, 5);
    check("ovf_frame_done", o_frame_done, 1);
    check("ovf_err", o_err, 1);
    tick();
    check("ovf_chk_count", chk_pulses - base_chk, 8);
    check("ovf_err_sticky", o_err, 1);
    i_game_start = 1; tick(); i_game_start = 0;
    check("gs_clr_err", o_err, 0);
    check("gs_clr_dir", o_direc_var, 0);

    // Watchdog: checker never answers
    i_cal_frame = 1; tick(); i_cal_frame = 0;
    i_ball_ack = 1; tick(); i_ball_ack = 0;
    tick();
    check("wd_wait", o_state, 3);
    for (int c = 0; c < 254; c++) tick();
    check("wd_still_wait", o_state, 3);
    check("wd_no_err_yet", o_err, 0);
    tick();
    check("wd_done", o_state, 5);
    check("wd_err", o_err, 1);
    check("wd_frame_done", o_frame_done, 1);
    tick();
    i_cal_frame = 1; tick(); i_cal_frame = 0;
    check("wd_next_frame", o_ball_req, 1);

    // Abort from WAIT_CHK with err set
    i_ball_ack = 1; tick(); i_ball_ack = 0;
    tick();
    i_chk_done = 1; i_chk_hit = 1; i_chk_dir = 5'd19; tick(); i_chk_done = 0; i_chk_hit = 0;
    tick();
    i_ball_ack = 1; i_ballX = 10'd77; tick(); i_ball_ack = 0;
    tick();
    i_cal_frame = 1; i_ball_ack = 1; i_ballX = 10'd1; tick(); i_cal_frame = 0; i_ball_ack = 0;
    check("ab_busy_ignore", o_state, 3);
    check("ab_ack_ignore", o_chkX, 77);
    check("ab_err_pre", o_err, 1);
    check("ab_dir_pre", o_direc_var, 19);
    i_game_start = 1; tick(); i_game_start = 0;
    check("ab_idle", o_state, 0);
    check("ab_err_clr", o_err, 0);
    check("ab_req_low", o_ball_req, 0);
    check("ab_dir_clr", o_direc_var, 0);
    i_chk_done = 1; i_chk_hit = 1; i_chk_dir = 5'd18; tick(); i_chk_done = 0; i_chk_hit = 0;
    check("ab_late_state", o_state, 0);
    check("ab_late_coll", o_ball_collision, 0);
    check("ab_late_dir", o_direc_var, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
